maze_pingpong_ctrl: RTL

Sequencer for the two maze framebuffer RAMs that feed `maze_color` to the sprite compositor. It services tile-paint requests from game logic by writing 8x8 tiles into the back buffer. At vertical blanking it swaps front and back buffers. After each swap it replays the previous frame's edits into the new back buffer so both copies stay identical. The display always reads the front buffer through the compositor's 16-bit address; 65535 means off-maze.

---
 rtl/maze_pingpong_ctrl_if.sv | 12 +
 rtl/maze_pingpong_ctrl.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/maze_pingpong_ctrl_if.sv
// Tile-paint request handshake between game logic (master) and the maze ping-pong sequencer
// (slave).
interface maze_pingpong_ctrl_if;
    logic       req_valid;
    logic       req_ready;
    logic [4:0] req_tx;
    logic [5:0] req_ty;
    logic [7:0] req_color;

    modport master (output req_valid, req_tx, req_ty, req_color, input req_ready);
    modport slave  (input req_valid, req_tx, req_ty, req_color, output req_ready);
endinterface

// File: rtl/maze_pingpong_ctrl.sv
// Maze framebuffer ping-pong sequencer: paints 8x8 tiles into the back RAM, swaps at vblank and
// replays the frame's edits into the new back RAM. Define PP_STATS_EN for swap/stall counters.
module maze_pingpong_ctrl #(
    parameter int unsigned LOG_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [9:0]           hc_i,
    input  logic [9:0]           vc_i,
    input  logic [15:0]          rd_addr_i,
    maze_pingpong_ctrl_if.slave  req_if,
    output logic [15:0]          buf0_addr_o,
    output logic                 buf0_we_o,
    output logic [7:0]           buf0_wdata_o,
    input  logic [7:0]           buf0_q_i,
    output logic [15:0]          buf1_addr_o,
    output logic                 buf1_we_o,
    output logic [7:0]           buf1_wdata_o,
    input  logic [7:0]           buf1_q_i,
    output logic                 front_sel_o,
    output logic [7:0]           maze_color_o,
`ifdef PP_STATS_EN
    output logic [15:0]          swap_count_o,
    output logic [15:0]          stall_count_o,
`endif
    output logic                 busy_o
);

    localparam int unsigned CntW = $clog2(LOG_DEPTH + 1);
    localparam int unsigned IdxW = (LOG_DEPTH > 1) ? $clog2(LOG_DEPTH) : 1;

    typedef enum logic [1:0] {StIdle, StFill, StSwap, StReplay} state_e;

    state_e              state_q, state_d;
    logic                front_sel_q, front_sel_d;
    logic                pend_q, pend_d;
    logic [CntW-1:0]     log_cnt_q, log_cnt_d;
    logic [CntW-1:0]     idx_q, idx_d;
    logic [2:0]          px_q, px_d, py_q, py_d;
    logic [4:0]          cur_tx_q, cur_tx_d;
    logic [5:0]          cur_ty_q, cur_ty_d;
    logic [7:0]          cur_color_q, cur_color_d;
    logic [4:0]          log_tx_q    [LOG_DEPTH];
    logic [5:0]          log_ty_q    [LOG_DEPTH];
    logic [7:0]          log_color_q [LOG_DEPTH];
    logic                log_we;

    logic                req_ready;
    logic                vblank;
    logic [4:0]          tile_tx;
    logic [5:0]          tile_ty;
    logic [7:0]          tile_color;
    logic [15:0]         fill_addr;
    logic                back_we;
    logic [15:0]         back_addr;
    logic [7:0]          back_wdata;
    logic                last_pix;

    logic                rd_off_q;
    logic                sel_d1_q;
    logic [7:0]          maze_color_q;

    logic                unused_hc;
    assign unused_hc = ^hc_i;

    assign vblank   = (vc_i >= 10'd480);
    assign last_pix = (px_q == 3'd7) && (py_q == 3'd7);

    // Replay reads its tile from the log; a live fill uses the latched request.
    assign tile_tx    = (state_q == StReplay) ? log_tx_q[IdxW'(idx_q)]    : cur_tx_q;
    assign tile_ty    = (state_q == StReplay) ? log_ty_q[IdxW'(idx_q)]    : cur_ty_q;
    assign tile_color = (state_q == StReplay) ? log_color_q[IdxW'(idx_q)] : cur_color_q;
    assign fill_addr  = 16'({8'd0, tile_tx, px_q} * 16'd264) + {7'd0, tile_ty, py_q};

    always_comb begin
        state_d     = state_q;
        front_sel_d = front_sel_q;
        pend_d      = pend_q;
        log_cnt_d   = log_cnt_q;
        idx_d       = idx_q;
        px_d        = px_q;
        py_d        = py_q;
        cur_tx_d    = cur_tx_q;
        cur_ty_d    = cur_ty_q;
        cur_color_d = cur_color_q;
        log_we      = 1'b0;
        req_ready   = 1'b0;
        back_we     = 1'b0;
        back_addr   = 16'd0;
        back_wdata  = 8'd0;
        unique case (state_q)
            StIdle: begin
                req_ready = (log_cnt_q < CntW'(LOG_DEPTH));
                if (req_if.req_valid && req_ready) begin
                    cur_tx_d    = req_if.req_tx;
                    cur_ty_d    = req_if.req_ty;
                    cur_color_d = req_if.req_color;
                    log_we      = 1'b1;
                    log_cnt_d   = log_cnt_q + 1'b1;
                    pend_d      = 1'b1;
                    px_d        = 3'd0;
                    py_d        = 3'd0;
                    state_d     = StFill;
                end else if (vblank && pend_q) begin
                    state_d = StSwap;
                end
            end
            StFill: begin
                back_we      = 1'b1;
                back_addr    = fill_addr;
                back_wdata   = tile_color;
                {px_d, py_d} = {px_q, py_q} + 6'd1;
                if (last_pix) state_d = StIdle;
            end
            StSwap: begin
                front_sel_d = ~front_sel_q;
                idx_d       = '0;
                px_d        = 3'd0;
                py_d        = 3'd0;
                state_d     = StReplay;
            end
            StReplay: begin
                back_we      = 1'b1;
                back_addr    = fill_addr;
                back_wdata   = tile_color;
                {px_d, py_d} = {px_q, py_q} + 6'd1;
                if (last_pix) begin
                    if (idx_q == log_cnt_q - 1'b1) begin
                        log_cnt_d = '0;
                        pend_d    = 1'b0;
                        state_d   = StIdle;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            front_sel_q <= 1'b0;
            pend_q      <= 1'b0;
            log_cnt_q   <= '0;
            idx_q       <= '0;
            px_q        <= 3'd0;
            py_q        <= 3'd0;
            cur_tx_q    <= 5'd0;
            cur_ty_q    <= 6'd0;
            cur_color_q <= 8'd0;
        end else begin
            state_q     <= state_d;
            front_sel_q <= front_sel_d;
            pend_q      <= pend_d;
            log_cnt_q   <= log_cnt_d;
            idx_q       <= idx_d;
            px_q        <= px_d;
            py_q        <= py_d;
            cur_tx_q    <= cur_tx_d;
            cur_ty_q    <= cur_ty_d;
            cur_color_q <= cur_color_d;
        end
    end

    // Log contents are only meaningful below log_cnt_q, so they need no reset.
    always_ff @(posedge clk) begin
        if (log_we) begin
            log_tx_q[IdxW'(log_cnt_q)]    <= req_if.req_tx;
            log_ty_q[IdxW'(log_cnt_q)]    <= req_if.req_ty;
            log_color_q[IdxW'(log_cnt_q)] <= req_if.req_color;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_off_q     <= 1'b0;
            sel_d1_q     <= 1'b0;
            maze_color_q <= 8'd0;
        end else begin
            rd_off_q     <= (rd_addr_i == 16'hFFFF);
            sel_d1_q     <= front_sel_q;
            maze_color_q <= rd_off_q ? 8'd0 : (sel_d1_q ? buf1_q_i : buf0_q_i);
        end
    end

`ifdef PP_STATS_EN
    logic [15:0] swap_cnt_q, stall_cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            swap_cnt_q  <= 16'd0;
            stall_cnt_q <= 16'd0;
        end else begin
            if (state_q == StSwap) swap_cnt_q <= swap_cnt_q + 16'd1;
            if (req_if.req_valid && !req_ready && (stall_cnt_q != 16'hFFFF)) begin
                stall_cnt_q <= stall_cnt_q + 16'd1;
            end
        end
    end

    assign swap_count_o  = swap_cnt_q;
    assign stall_count_o = stall_cnt_q;
`endif

    assign req_if.req_ready = req_ready;

    assign buf0_addr_o  = front_sel_q ? back_addr  : rd_addr_i;
    assign buf0_we_o    = front_sel_q ? back_we    : 1'b0;
    assign buf0_wdata_o = front_sel_q ? back_wdata : 8'd0;
    assign buf1_addr_o  = front_sel_q ? rd_addr_i  : back_addr;
    assign buf1_we_o    = front_sel_q ? 1'b0       : back_we;
    assign buf1_wdata_o = front_sel_q ? 8'd0       : back_wdata;

    assign front_sel_o  = front_sel_q;
    assign maze_color_o = maze_color_q;
    assign busy_o       = (state_q != StIdle);

endmodule
